// File: rtl/riot_pkg.sv
// riot_pkg: shared constants for the RIOT I/O block.
//   - register addresses for the timer, status and PA7 edge-detect config
//   - timer interval encodings (from adr_i[1:0] of a timer write)
//   - status register bit positions
//   - address decode helpers used by riot_io
package riot_pkg;

    typedef enum logic [1:0] {
        DIV_1    = 2'd0,
        DIV_8    = 2'd1,
        DIV_64   = 2'd2,
        DIV_1024 = 2'd3
    } riot_div_e;

    localparam logic [6:0] ADR_INTIM   = 7'h04;
    localparam logic [6:0] ADR_STATUS  = 7'h05;

    localparam int unsigned STAT_TIMINT_BIT = 7;
    localparam int unsigned STAT_PA7INT_BIT = 6;

    localparam logic [7:0] INTIM_RESET = 8'hFF;

    // Terminal prescaler count for each interval (interval - 1).
    function automatic logic [9:0] div_last(input riot_div_e div);
        case (div)
            DIV_1:    return 10'd0;
            DIV_8:    return 10'd7;
            DIV_64:   return 10'd63;
            default:  return 10'd1023;
        endcase
    endfunction

    // Data register address of port p; DDR lives at this address + 1.
    function automatic logic [6:0] port_data_adr(input int unsigned p);
        if (p < 2) return 7'(2 * p);
        else       return 7'(8 + 2 * (p - 2));
    endfunction

    // 0x14-0x17 and 0x1C-0x1F: adr[3] carries the interrupt enable.
    function automatic logic is_timer_adr(input logic [6:0] adr);
        return (adr[6:4] == 3'b001) && adr[2];
    endfunction

    // 0x04-0x07: PA7 edge-detect configuration writes.
    function automatic logic is_pa7_cfg_adr(input logic [6:0] adr);
        return adr[6:2] == 5'b00001;
    endfunction

endpackage

// File: rtl/riot_timer.sv
// riot_timer: programmable interval timer (prescaler, INTIM, TIMINT).
// Ports:
//   clk_i, rst_i, enable_i  clock, synchronous active-high reset, clock enable
//   load      load INTIM from load_val with interval load_div, IE load_ie
//   load_div  interval select for a load
//   load_ie   timer interrupt enable for a load
//   load_val  new INTIM value
//   rd_intim  INTIM is being read (clears TIMINT)
//   intim     current INTIM
//   timint    timer underflow flag
//   tim_ie    timer interrupt enable
module riot_timer
    import riot_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       load,
    input  riot_div_e  load_div,
    input  logic       load_ie,
    input  logic [7:0] load_val,
    input  logic       rd_intim,
    output logic [7:0] intim,
    output logic       timint,
    output logic       tim_ie
);

    riot_div_e  div;
    logic [9:0] presc;
    logic       tick;
    logic       underflow;

    assign tick      = (presc == div_last(div));
    assign underflow = tick && (intim == 8'h00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            intim  <= INTIM_RESET;
            presc  <= '0;
            div    <= DIV_1024;
            timint <= 1'b0;
            tim_ie <= 1'b0;
        end else if (enable_i) begin
            if (load) begin
                intim  <= load_val;
                presc  <= '0;
                div    <= load_div;
                timint <= 1'b0;
                tim_ie <= load_ie;
            end else begin
                if (tick) begin
                    presc <= '0;
                    intim <= intim - 8'd1;
                end else begin
                    presc <= presc + 10'd1;
                end
                // After underflow the timer free-runs at interval 1.
                if (underflow) begin
                    div    <= DIV_1;
                    timint <= 1'b1;
                end else if (rd_intim) begin
                    timint <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/riot_io.sv
// riot_io: RIOT-style I/O block with NPORTS 8-bit ports, interval timer
// and optional PA7 edge interrupt.
// Ports:
//   clk_i, rst_i, enable_i  clock, synchronous active-high reset, clock enable
//   stb_i, we_i, adr_i      access strobe, write enable, register address
//   dat_i / dat_o           write data / registered read data
//   port_i                  pin inputs, port p at [8p+7:8p]
//   port_o                  output data registers
//   port_oe                 per-bit output enables (the DDR)
//   irq_o                   registered interrupt request
// Build option: define RIOT_PA7_EDGE_EN to include the PA7 edge detector.
module riot_io
    import riot_pkg::*;
#(
    parameter int unsigned NPORTS    = 2,
    parameter logic [7:0]  RESET_DDR = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [6:0]            adr_i,
    input  logic [7:0]            dat_i,
    output logic [7:0]            dat_o,
    input  logic [8*NPORTS-1:0]   port_i,
    output logic [8*NPORTS-1:0]   port_o,
    output logic [8*NPORTS-1:0]   port_oe,
    output logic                  irq_o
);

    logic       acc, wr, rd;
    logic       tim_load, rd_intim, rd_status;
    logic [7:0] intim;
    logic       timint, tim_ie;
    logic       pa7int, pa7_ie;
    logic [7:0] status;
    logic [7:0] rd_data;

    assign acc       = enable_i && stb_i && !rst_i;
    assign wr        = acc && we_i;
    assign rd        = acc && !we_i;
    assign tim_load  = wr && is_timer_adr(adr_i);
    assign rd_intim  = rd && (adr_i == ADR_INTIM);
    assign rd_status = rd && (adr_i == ADR_STATUS);

    riot_timer u_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .load     (tim_load),
        .load_div (riot_div_e'(adr_i[1:0])),
        .load_ie  (adr_i[3]),
        .load_val (dat_i),
        .rd_intim (rd_intim),
        .intim    (intim),
        .timint   (timint),
        .tim_ie   (tim_ie)
    );

`ifdef RIOT_PA7_EDGE_EN
    logic pa7_q;
    logic pa7_rise;
    logic pa7_edge;

    assign pa7_edge = pa7_rise ? (!pa7_q &&  port_i[7])
                               : ( pa7_q && !port_i[7]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pa7_q    <= port_i[7];
            pa7_rise <= 1'b0;
            pa7_ie   <= 1'b0;
            pa7int   <= 1'b0;
        end else if (enable_i) begin
            pa7_q <= port_i[7];
            if (wr && is_pa7_cfg_adr(adr_i)) begin
                pa7_rise <= adr_i[0];
                pa7_ie   <= adr_i[1];
            end
            if (pa7_edge)       pa7int <= 1'b1;
            else if (rd_status) pa7int <= 1'b0;
        end
    end
`else
    assign pa7int = 1'b0;
    assign pa7_ie = 1'b0;
`endif

    always_comb begin
        status                  = '0;
        status[STAT_TIMINT_BIT] = timint;
        status[STAT_PA7INT_BIT] = pa7int;
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned p = 0; p < NPORTS; p++) begin
            if (adr_i == port_data_adr(p))
                rd_data = (port_o[8*p +: 8] & port_oe[8*p +: 8]) |
                          (port_i[8*p +: 8] & ~port_oe[8*p +: 8]);
            if (adr_i == port_data_adr(p) + 7'd1)
                rd_data = port_oe[8*p +: 8];
        end
        if (adr_i == ADR_INTIM)  rd_data = intim;
        if (adr_i == ADR_STATUS) rd_data = status;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_o   <= '0;
            port_o  <= '0;
            port_oe <= {NPORTS{RESET_DDR}};
            irq_o   <= 1'b0;
        end else if (enable_i) begin
            if (wr) begin
                for (int unsigned p = 0; p < NPORTS; p++) begin
                    if (adr_i == port_data_adr(p))
                        port_o[8*p +: 8] <= dat_i;
                    if (adr_i == port_data_adr(p) + 7'd1)
                        port_oe[8*p +: 8] <= dat_i;
                end
            end
            if (rd) dat_o <= rd_data;
            irq_o <= (timint && tim_ie) || (pa7int && pa7_ie);
        end
    end

endmodule

// File: doc/riot_io.md
RIOT_IO -- requirements
Module: riot_io

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of 8-bit I/O ports (1..4).
REQ-002 SHALL have parameter RESET_DDR, default 8'h00, data-direction reset value applied to every port.
REQ-003 SHALL have ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  clock enable; all state frozen when low.
- stb_i  in  1  access strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  7  register address.
- dat_i  in  8  write data.
- dat_o  out  8  registered read data.
- port_i  in  8*NPORTS  pin inputs; port p at bits [8p+7:8p].
- port_o  out  8*NPORTS  output data registers.
- port_oe  out  8*NPORTS  per-bit output enables (= DDR).
- irq_o  out  1  interrupt request, active high.

Function
REQ-004 SHALL count a valid access only when enable_i=1, stb_i=1 and rst_i=0.
REQ-005 SHALL map port p (p<NPORTS) data at 0x00+2p for p<2 and 0x08+2(p-2) for p>=2, with DDR at data address +1; unmapped reads return 8'h00, unmapped writes are ignored.
REQ-006 SHALL return port data reads as (port_o & DDR) | (port_i & ~DDR), and DDR reads as DDR.
REQ-007 SHALL update dat_o on the enabled cycle after the read is sampled; dat_o holds between reads.
REQ-008 SHALL load the timer on a write to 0x14/0x15/0x16/0x17: INTIM<=dat_i, interval 1/8/64/1024, prescaler<=0, TIMINT<=0.
REQ-009 SHALL set the timer interrupt enable from adr_i[3] on a timer write (0x1C-0x1F = same timer load with IE=1).
REQ-010 SHALL decrement INTIM when the prescaler reaches interval-1, then clear the prescaler.
REQ-011 SHALL, on an INTIM decrement from 8'h00, wrap INTIM to 8'hFF, set TIMINT and switch the interval to 1 until the next timer write.
REQ-012 SHALL return INTIM at 0x04 and {TIMINT, PA7INT, 6'b0} at 0x05.
REQ-013 SHALL clear TIMINT on an INTIM read; an underflow on the same cycle SHALL leave TIMINT set.
REQ-014 SHALL give a timer write priority over a decrement or underflow on the same cycle.
REQ-015 SHALL drive irq_o = (TIMINT & TIM_IE) | (PA7INT & PA7_IE), registered.

Reset
REQ-016 SHALL, on rst_i=1 regardless of enable_i, set: dat_o=0; port_o=0; DDR=RESET_DDR; INTIM=8'hFF; prescaler=0; interval=1024; TIMINT=0; TIM_IE=0; PA7INT=0; PA7_IE=0; edge select=falling; irq_o=0.
REQ-017 SHALL, on reset mid-count, abandon the count with no flag set.

Configuration
REQ-018 SHALL compile the PA7 edge detector only when RIOT_PA7_EDGE_EN is defined:
- Port 0 bit 7 pin value is sampled each enabled cycle.
- A write to 0x04-0x07 sets edge select = adr_i[0] (1 = rising) and PA7_IE = adr_i[1].
- A matching edge sets PA7INT.
- A read of 0x05 clears PA7INT; an edge on the same cycle wins.
REQ-019 SHALL, without RIOT_PA7_EDGE_EN: hold PA7INT at 0; ignore writes to 0x04-0x07; read PA7INT as 0 and exclude it from irq_o.

Structure
REQ-020 SHALL place address constants, interval encodings and the status bit positions in shared package riot_pkg.
REQ-021 SHALL implement the prescaler/INTIM/TIMINT logic in sub-module riot_timer, instantiated once.

Verification
REQ-022 Bench SHALL cover:
- DDR0=8'hF0, port_o0=8'hA5, port_i0=8'h3C -> read 0x00 returns 8'hAC.
- Write 0x15 with 8'h02 -> INTIM reads 2, 1, 0 at 8-cycle steps, then 8'hFF with TIMINT=1, then 8'hFE one cycle later.
- Write 0x1C with 8'h00 -> irq_o=1 two cycles later; an INTIM read clears TIMINT and irq_o.
- Timer write on the exact underflow cycle -> INTIM=dat_i and TIMINT=0.
- enable_i held low 50 cycles mid-count -> INTIM unchanged.
- With RIOT_PA7_EDGE_EN, write 0x07 then drive pin 1->0->1 -> PA7INT set only after the rising edge; irq_o=1.
